// File: rtl/ireg_write_arbiter.sv
// Two-port round-robin register-file write arbiter with an optional pending-write
// scoreboard, enabled by defining IREG_SCOREBOARD_EN.
module ireg_write_arbiter #(
  parameter int AW = 6,
  parameter int DW = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [AW-1:0]     req0_addr,
  input  logic [DW-1:0]     req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [AW-1:0]     req1_addr,
  input  logic [DW-1:0]     req1_data,
  output logic              req1_ready,
  output logic              we,
  output logic [AW-1:0]     rw,
  output logic [DW-1:0]     dw,
  input  logic              mark_valid,
  input  logic [AW-1:0]     mark_addr,
  input  logic [AW-1:0]     q0_addr,
  input  logic [AW-1:0]     q1_addr,
  output logic              q0_busy,
  output logic              q1_busy,
  output logic [2**AW-1:0]  busy_vec,
  output logic              sb_err
);

  typedef enum logic {PORT0 = 1'b0, PORT1 = 1'b1} port_e;

  port_e          last_q, last_d;
  logic           we_q, we_d;
  logic [AW-1:0]  rw_q, rw_d;
  logic [DW-1:0]  dw_q, dw_d;

  // Readies are gated by rst_n so nothing is accepted while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    if (rst_n) begin
      if (req0_valid && req1_valid) begin
        if (last_q == PORT1) req0_ready = 1'b1;
        else                 req1_ready = 1'b1;
      end else if (req0_valid) begin
        req0_ready = 1'b1;
      end else if (req1_valid) begin
        req1_ready = 1'b1;
      end
    end
  end

  always_comb begin
    last_d = last_q;
    we_d   = 1'b0;
    rw_d   = rw_q;
    dw_d   = dw_q;
    if (req0_ready) begin
      last_d = PORT0;
      we_d   = 1'b1;
      rw_d   = req0_addr;
      dw_d   = req0_data;
    end else if (req1_ready) begin
      last_d = PORT1;
      we_d   = 1'b1;
      rw_d   = req1_addr;
      dw_d   = req1_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PORT1;
      we_q   <= 1'b0;
      rw_q   <= '0;
      dw_q   <= '0;
    end else begin
      last_q <= last_d;
      we_q   <= we_d;
      rw_q   <= rw_d;
      dw_q   <= dw_d;
    end
  end

  assign we = we_q;
  assign rw = rw_q;
  assign dw = dw_q;

`ifdef IREG_SCOREBOARD_EN
  logic [2**AW-1:0] busy_q, busy_d;
  logic             sb_err_q, sb_err_d;

  // Clear is applied before mark so a same-address mark wins.
  always_comb begin
    busy_d   = busy_q;
    sb_err_d = sb_err_q;
    if (we_q) busy_d[rw_q] = 1'b0;
    if (mark_valid) begin
      busy_d[mark_addr] = 1'b1;
      if (busy_q[mark_addr] && !(we_q && (rw_q == mark_addr))) sb_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q   <= '0;
      sb_err_q <= 1'b0;
    end else begin
      busy_q   <= busy_d;
      sb_err_q <= sb_err_d;
    end
  end

  assign busy_vec = busy_q;
  assign sb_err   = sb_err_q;
  assign q0_busy  = busy_q[q0_addr];
  assign q1_busy  = busy_q[q1_addr];
`else
  logic unused_sb_inputs;
  assign unused_sb_inputs = ^{mark_valid, mark_addr, q0_addr, q1_addr};

  assign busy_vec = '0;
  assign sb_err   = 1'b0;
  assign q0_busy  = 1'b0;
  assign q1_busy  = 1'b0;
`endif

endmodule

// File: tb/tb_ireg_write_arbiter.sv
// Directed self-checking bench for ireg_write_arbiter; scoreboard expectations
// follow whether IREG_SCOREBOARD_EN is defined for the build.
module tb_ireg_write_arbiter;

  localparam int AW = 6;
  localparam int DW = 32;
`ifdef IREG_SCOREBOARD_EN
  localparam logic SB = 1'b1;
`else
  localparam logic SB = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req0_valid, req1_valid;
  logic [AW-1:0]     req0_addr, req1_addr;
  logic [DW-1:0]     req0_data, req1_data;
  logic              req0_ready, req1_ready;
  logic              we;
  logic [AW-1:0]     rw;
  logic [DW-1:0]     dw;
  logic              mark_valid;
  logic [AW-1:0]     mark_addr, q0_addr, q1_addr;
  logic              q0_busy, q1_busy;
  logic [2**AW-1:0]  busy_vec;
  logic              sb_err;

  int unsigned checks = 0;
  int unsigned errors = 0;

  ireg_write_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_data(req1_data), .req1_ready(req1_ready),
    .we(we), .rw(rw), .dw(dw),
    .mark_valid(mark_valid), .mark_addr(mark_addr),
    .q0_addr(q0_addr), .q1_addr(q1_addr), .q0_busy(q0_busy), .q1_busy(q1_busy),
    .busy_vec(busy_vec), .sb_err(sb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
    req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
    mark_valid = 1'b0; mark_addr = '0; q0_addr = '0; q1_addr = '0;

    // Reset state; ready must stay low under reset even with a request.
    step();
    req0_valid = 1'b1;
    #1;
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_we", we, 1'b0);
    chk("rst_rw", rw, 6'd0);
    chk("rst_dw", dw, 32'd0);
    chk("rst_busy", busy_vec, 64'd0);
    chk("rst_err", sb_err, 1'b0);
    req0_valid = 1'b0;
    #2 rst_n = 1'b1;
    step();

    // Single request on port 0.
    req0_valid = 1'b1; req0_addr = 6'd5; req0_data = 32'h1234;
    #1;
    chk("single_rdy0", req0_ready, 1'b1);
    chk("single_rdy1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0;
    chk("single_we", we, 1'b1);
    chk("single_rw", rw, 6'd5);
    chk("single_dw", dw, 32'h1234);
    step();
    chk("idle_we", we, 1'b0);
    chk("hold_rw", rw, 6'd5);
    chk("hold_dw", dw, 32'h1234);

    // Port-1 write leaves the pointer at port 1 so contention starts at port 0.
    req1_valid = 1'b1; req1_addr = 6'd3; req1_data = 32'h33;
    #1;
    chk("p1_rdy1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    chk("p1_rw", rw, 6'd3);
    step();

    // Contention: grants alternate 0,1,0,1 with a write every cycle.
    req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_rdy0", req0_ready, (i % 2 == 0));
      chk("rr_rdy1", req1_ready, (i % 2 == 1));
      step();
      chk("rr_we", we, 1'b1);
      chk("rr_rw", rw, (i % 2 == 0) ? 6'd1 : 6'd2);
      chk("rr_dw", dw, (i % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    step();
    chk("rr_end_we", we, 1'b0);

    // Mark 7, then a port-1 write to 7 clears it two cycles after handshake.
    mark_valid = 1'b1; mark_addr = 6'd7;
    step();
    mark_valid = 1'b0; q0_addr = 6'd7;
    #1;
    chk("mark7_q0", q0_busy, SB);
    chk("mark7_vec", busy_vec[7], SB);
    req1_valid = 1'b1; req1_addr = 6'd7; req1_data = 32'h77;
    #1;
    chk("w7_rdy1", req1_ready, 1'b1);
    step();
    req1_valid = 1'b0;
    chk("w7_we", we, 1'b1);
    chk("w7_rw", rw, 6'd7);
    chk("w7_q0_still", q0_busy, SB);
    step();
    chk("w7_q0_clr", q0_busy, 1'b0);
    chk("w7_err", sb_err, 1'b0);

    // Mark 9, write 9 while re-marking 9: mark wins, no error.
    mark_valid = 1'b1; mark_addr = 6'd9;
    step();
    mark_valid = 1'b0;
    req0_valid = 1'b1; req0_addr = 6'd9; req0_data = 32'h99;
    step();
    req0_valid = 1'b0;
    chk("w9_we", we, 1'b1);
    chk("w9_rw", rw, 6'd9);
    mark_valid = 1'b1; mark_addr = 6'd9;
    step();
    mark_valid = 1'b0; q1_addr = 6'd9;
    #1;
    chk("mw9_vec", busy_vec[9], SB);
    chk("mw9_q1", q1_busy, SB);
    chk("mw9_err", sb_err, 1'b0);
    // A second mark of busy 9 is an error, and it is sticky.
    mark_valid = 1'b1;
    step();
    mark_valid = 1'b0;
    chk("dbl9_err", sb_err, SB);
    chk("dbl9_vec", busy_vec[9], SB);
    step();
    step();
    chk("err_sticky", sb_err, SB);

    // Reset mid-burst drops the pending write and scoreboard immediately.
    req0_valid = 1'b1; req0_addr = 6'd1; req0_data = 32'hA1;
    req1_valid = 1'b1; req1_addr = 6'd2; req1_data = 32'hB2;
    step();
    chk("burst_we", we, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_we", we, 1'b0);
    chk("arst_rw", rw, 6'd0);
    chk("arst_dw", dw, 32'd0);
    chk("arst_busy", busy_vec, 64'd0);
    chk("arst_err", sb_err, 1'b0);
    chk("arst_rdy0", req0_ready, 1'b0);
    chk("arst_rdy1", req1_ready, 1'b0);
    step();
    #2 rst_n = 1'b1;
    #1;
    chk("post_rdy0", req0_ready, 1'b1);
    chk("post_rdy1", req1_ready, 1'b0);
    step();
    req0_valid = 1'b0; req1_valid = 1'b0;
    chk("post_rw", rw, 6'd1);
    chk("post_dw", dw, 32'hA1);
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
